// File: rtl/sram2_vec_ctrl.sv
// ----------------------------------------------------------------------------
// sram2_vec_ctrl
//
// Element-wise vector add/subtract engine for a dual-read, single-write SRAM.
// A job reads len elements from A (base_a) and B (base_b), computes A+B or
// A-B at data_width bits with two's-complement wrap, and writes the results
// to C (base_c). One element is issued per cycle with no bubbles.
//
// The SRAM registers its inputs on the clock edge. Read data is valid in the
// cycle after an address is driven, and a write commits on the second edge
// after sram_write is driven.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, op                  job request (sampled in IDLE), 0 = A+B, 1 = A-B
//   base_a, base_b, base_c     operand / result base addresses
//   len                        element count, 0 .. 2^addr_width
//   busy, done                 busy in every non-IDLE state, 1-cycle done pulse
//   sram_raddr_a/b             SRAM read addresses
//   sram_dout_a/b              SRAM read data
//   sram_waddr, sram_din,
//   sram_write                 SRAM write port
// ----------------------------------------------------------------------------
module sram2_vec_ctrl #(
    parameter int addr_width = 11,
    parameter int data_width = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         op,
    input  logic [addr_width-1:0]        base_a,
    input  logic [addr_width-1:0]        base_b,
    input  logic [addr_width-1:0]        base_c,
    input  logic [addr_width:0]          len,
    output logic                         busy,
    output logic                         done,
    output logic [addr_width-1:0]        sram_raddr_a,
    output logic [addr_width-1:0]        sram_raddr_b,
    input  logic signed [data_width-1:0] sram_dout_a,
    input  logic signed [data_width-1:0] sram_dout_b,
    output logic [addr_width-1:0]        sram_waddr,
    output logic signed [data_width-1:0] sram_din,
    output logic                         sram_write
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [addr_width:0]   len_zero  = '0;
    localparam logic [addr_width:0]   len_one   = {{addr_width{1'b0}}, 1'b1};
    localparam logic [addr_width-1:0] addr_zero = '0;
    localparam logic [data_width-1:0] data_zero = '0;
    localparam logic [1:0]            drain_last = 2'd2;

    // Wrapping add/subtract of the two operands.
    function automatic logic signed [data_width-1:0] calc_result(
        input logic                         sub,
        input logic signed [data_width-1:0] a,
        input logic signed [data_width-1:0] b
    );
        logic signed [data_width-1:0] r;
        if (sub) begin
            r = a - b;
        end else begin
            r = a + b;
        end
        return r;
    endfunction

    state_t                       state_r;
    state_t                       state_next_s;

    logic                         op_r;
    logic [addr_width-1:0]        base_a_r;
    logic [addr_width-1:0]        base_b_r;
    logic [addr_width-1:0]        base_c_r;
    logic [addr_width:0]          len_r;
    logic [addr_width:0]          idx_r;       // element whose read is driven this cycle
    logic [addr_width:0]          idx_inc_s;
    logic                         last_issue_s;
    logic                         job_start_s;
    logic [1:0]                   drain_cnt_r;

    logic                         rd_valid_r;  // SRAM read data is valid this cycle
    logic [addr_width-1:0]        rd_idx_r;    // element index of that read data

    logic                         busy_r;
    logic                         done_r;
    logic [addr_width-1:0]        raddr_a_r;
    logic [addr_width-1:0]        raddr_b_r;
    logic [addr_width-1:0]        waddr_r;
    logic signed [data_width-1:0] din_r;
    logic                         write_r;

    assign idx_inc_s    = idx_r + len_one;
    assign last_issue_s = (idx_r == (len_r - len_one));
    assign job_start_s  = start && (len != len_zero);

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    // An empty job skips straight to DONE without touching the SRAM.
                    if (len == len_zero) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (last_issue_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            DRAIN: begin
                // Three drain cycles cover read latency, result write and the
                // SRAM's commit of the final write.
                if (drain_cnt_r == drain_last) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with registered busy/done status derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Drain cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r <= 2'd0;
        end else if (state_r == DRAIN) begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
        end else begin
            drain_cnt_r <= 2'd0;
        end
    end

    // Job capture and read-address issue; addresses wrap modulo 2^addr_width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 1'b0;
            base_a_r  <= addr_zero;
            base_b_r  <= addr_zero;
            base_c_r  <= addr_zero;
            len_r     <= len_zero;
            idx_r     <= len_zero;
            raddr_a_r <= addr_zero;
            raddr_b_r <= addr_zero;
        end else begin
            case (state_r)
                IDLE: begin
                    if (job_start_s) begin
                        op_r      <= op;
                        base_a_r  <= base_a;
                        base_b_r  <= base_b;
                        base_c_r  <= base_c;
                        len_r     <= len;
                        idx_r     <= len_zero;
                        raddr_a_r <= base_a;
                        raddr_b_r <= base_b;
                    end
                end
                ISSUE: begin
                    if (!last_issue_s) begin
                        idx_r     <= idx_inc_s;
                        raddr_a_r <= base_a_r + idx_inc_s[addr_width-1:0];
                        raddr_b_r <= base_b_r + idx_inc_s[addr_width-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result pipeline: read data arrives one cycle after issue, the result
    // register doubles as the write-data output in the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_idx_r   <= addr_zero;
            waddr_r    <= addr_zero;
            din_r      <= data_zero;
            write_r    <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == ISSUE);
            rd_idx_r   <= idx_r[addr_width-1:0];
            if (rd_valid_r) begin
                din_r   <= calc_result(op_r, sram_dout_a, sram_dout_b);
                waddr_r <= base_c_r + rd_idx_r;
                write_r <= 1'b1;
            end else begin
                write_r <= 1'b0;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign sram_raddr_a = raddr_a_r;
    assign sram_raddr_b = raddr_b_r;
    assign sram_waddr   = waddr_r;
    assign sram_din     = din_r;
    assign sram_write   = write_r;

endmodule

// File: tb/tb_sram2_vec_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram2_vec_ctrl
//
// Directed testbench for sram2_vec_ctrl with a behavioural dual-read SRAM:
// inputs registered on the edge, combinational read from the registered
// address, write committed from the registered write inputs one edge later.
// ----------------------------------------------------------------------------
module tb_sram2_vec_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 op;
    logic [AW-1:0]        base_a;
    logic [AW-1:0]        base_b;
    logic [AW-1:0]        base_c;
    logic [AW:0]          len;
    logic                 busy;
    logic                 done;
    logic [AW-1:0]        sram_raddr_a;
    logic [AW-1:0]        sram_raddr_b;
    logic signed [DW-1:0] sram_dout_a;
    logic signed [DW-1:0] sram_dout_b;
    logic [AW-1:0]        sram_waddr;
    logic signed [DW-1:0] sram_din;
    logic                 sram_write;

    int vec  = 0;
    int errs = 0;

    logic [AW-1:0] ra_log [8];
    logic [AW-1:0] rb_log [8];

    always #5 clk = ~clk;

    sram2_vec_ctrl #(.addr_width(AW), .data_width(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .base_a       (base_a),
        .base_b       (base_b),
        .base_c       (base_c),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .sram_raddr_a (sram_raddr_a),
        .sram_raddr_b (sram_raddr_b),
        .sram_dout_a  (sram_dout_a),
        .sram_dout_b  (sram_dout_b),
        .sram_waddr   (sram_waddr),
        .sram_din     (sram_din),
        .sram_write   (sram_write)
    );

    // SRAM model plus a bench-side load port.
    logic signed [DW-1:0] mem [DEPTH];
    logic [AW-1:0]        ra_q, rb_q, wa_q, ld_addr;
    logic signed [DW-1:0] wd_q, ld_data;
    logic                 we_q, ld_en;

    always @(posedge clk) begin
        ra_q <= sram_raddr_a;
        rb_q <= sram_raddr_b;
        wa_q <= sram_waddr;
        wd_q <= sram_din;
        we_q <= sram_write;
        if (we_q) mem[wa_q] <= wd_q;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    assign sram_dout_a = mem[ra_q];
    assign sram_dout_b = mem[rb_q];

    task automatic load_word(input logic [AW-1:0] a, input int d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
    endtask

    task automatic load_end();
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Drives one job from the current negedge and observes it cycle by cycle.
    // rel = cycles after the start-sampling edge. Returns the done cycle,
    // the write count and the number of cycles whose write/busy/done differ
    // from the expected timeline. Ends at the negedge of the first idle cycle.
    task automatic run_job(input logic op_i, input logic [AW-1:0] a_i,
                           input logic [AW-1:0] b_i, input logic [AW-1:0] c_i,
                           input logic [AW:0] n_i, input bit pester,
                           output int done_rel, output int wr_seen, output int bad);
        int   jobend;
        logic exp_wr;
        jobend   = (n_i == 12'd0) ? 1 : int'(n_i) + 4;
        start    = 1'b1;
        op       = op_i;
        base_a   = a_i;
        base_b   = b_i;
        base_c   = c_i;
        len      = n_i;
        done_rel = -1;
        wr_seen  = 0;
        bad      = 0;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= jobend + 1; rel++) begin
            exp_wr = (n_i != 12'd0) && (rel >= 3) && (rel <= jobend - 2);
            if (sram_write !== exp_wr) bad++;
            if (busy !== (rel <= jobend)) bad++;
            if (done !== (rel == jobend)) bad++;
            if (done === 1'b1 && done_rel < 0) done_rel = rel;
            if (sram_write === 1'b1) wr_seen++;
            if (rel <= 8) begin
                ra_log[rel-1] = sram_raddr_a;
                rb_log[rel-1] = sram_raddr_b;
            end
            if (pester && rel >= 2 && rel <= jobend) begin
                start  = 1'b1;
                op     = ~op_i;
                base_c = c_i + 11'h080;
                len    = n_i - 12'd1;
            end else begin
                start = 1'b0;
            end
            if (rel <= jobend) @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %0b, expected 0", done); end
        vec++; if (sram_write !== 1'b0) begin errs++; $display("FAIL reset_write: got %0b, expected 0", sram_write); end
        vec++; if (sram_raddr_a !== 11'h000 || sram_raddr_b !== 11'h000 || sram_waddr !== 11'h000)
            begin errs++; $display("FAIL reset_addr: got %h/%h/%h, expected 000/000/000", sram_raddr_a, sram_raddr_b, sram_waddr); end
        vec++; if (sram_din !== 32'h0) begin errs++; $display("FAIL reset_din: got %h, expected 00000000", sram_din); end
    endtask

    task automatic test_add_basic();
        int d, w, b;
        int ea [4] = '{1, 2, 3, 4};
        int eb [4] = '{10, 20, 30, 40};
        int ec [4] = '{11, 22, 33, 44};
        for (int k = 0; k < 4; k++) load_word(11'h000 + 11'(k), ea[k]);
        for (int k = 0; k < 4; k++) load_word(11'h100 + 11'(k), eb[k]);
        load_end();
        run_job(1'b0, 11'h000, 11'h100, 11'h200, 12'd4, 1'b0, d, w, b);
        vec++; if (d !== 8) begin errs++; $display("FAIL add_done_cycle: got %0d, expected 8", d); end
        vec++; if (w !== 4) begin errs++; $display("FAIL add_write_count: got %0d, expected 4", w); end
        vec++; if (b !== 0) begin errs++; $display("FAIL add_timeline: got %0d bad cycles, expected 0", b); end
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (mem[11'h200 + 11'(k)] !== ec[k]) begin
                errs++; $display("FAIL add_result[%0d]: got %0d, expected %0d", k, mem[11'h200 + 11'(k)], ec[k]);
            end
        end
    endtask

    task automatic test_sub_wrap();
        int d, w, b;
        load_word(11'h010, 5);
        load_word(11'h110, 7);
        load_word(11'h011, 32'h7FFFFFFF);
        load_word(11'h111, -1);
        load_end();
        run_job(1'b1, 11'h010, 11'h110, 11'h210, 12'd1, 1'b0, d, w, b);
        vec++; if (d !== 5 || w !== 1 || b !== 0) begin errs++; $display("FAIL sub_timing: got done %0d writes %0d bad %0d, expected 5 1 0", d, w, b); end
        vec++; if (mem[11'h210] !== 32'hFFFFFFFE) begin errs++; $display("FAIL sub_neg: got %h, expected fffffffe", mem[11'h210]); end
        run_job(1'b1, 11'h011, 11'h111, 11'h211, 12'd1, 1'b0, d, w, b);
        vec++; if (mem[11'h211] !== 32'h80000000) begin errs++; $display("FAIL sub_wrap: got %h, expected 80000000", mem[11'h211]); end
    endtask

    task automatic test_addr_wrap();
        int d, w, b;
        logic [AW-1:0] xa [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        logic [AW-1:0] xb [4] = '{11'h3FE, 11'h3FF, 11'h400, 11'h401};
        int ec [4] = '{101, 202, 303, 404};
        for (int k = 0; k < 4; k++) load_word(xa[k], 100 * (k + 1));
        for (int k = 0; k < 4; k++) load_word(xb[k], k + 1);
        load_end();
        run_job(1'b0, 11'h7FE, 11'h3FE, 11'h500, 12'd4, 1'b0, d, w, b);
        vec++; if (d !== 8 || w !== 4 || b !== 0) begin errs++; $display("FAIL wrap_timing: got done %0d writes %0d bad %0d, expected 8 4 0", d, w, b); end
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (ra_log[k] !== xa[k] || rb_log[k] !== xb[k]) begin
                errs++; $display("FAIL wrap_raddr[%0d]: got %h/%h, expected %h/%h", k, ra_log[k], rb_log[k], xa[k], xb[k]);
            end
        end
        vec++; if (sram_raddr_a !== 11'h001) begin errs++; $display("FAIL idle_hold_raddr: got %h, expected 001", sram_raddr_a); end
        vec++; if (sram_waddr !== 11'h503) begin errs++; $display("FAIL idle_hold_waddr: got %h, expected 503", sram_waddr); end
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (mem[11'h500 + 11'(k)] !== ec[k]) begin
                errs++; $display("FAIL wrap_result[%0d]: got %0d, expected %0d", k, mem[11'h500 + 11'(k)], ec[k]);
            end
        end
    endtask

    task automatic test_len_zero();
        int d, w, b;
        load_word(11'h600, 32'h55);
        load_end();
        run_job(1'b0, 11'h000, 11'h100, 11'h600, 12'd0, 1'b0, d, w, b);
        vec++; if (d !== 1) begin errs++; $display("FAIL len0_done: got %0d, expected 1", d); end
        vec++; if (w !== 0) begin errs++; $display("FAIL len0_writes: got %0d, expected 0", w); end
        vec++; if (b !== 0) begin errs++; $display("FAIL len0_timeline: got %0d bad cycles, expected 0", b); end
        vec++; if (mem[11'h600] !== 32'h55) begin errs++; $display("FAIL len0_mem: got %h, expected 00000055", mem[11'h600]); end
    endtask

    task automatic test_busy_ignore();
        int d, w, b;
        int ea [4] = '{7, 8, 9, 10};
        int eb [4] = '{-1, -2, -3, -4};
        for (int k = 0; k < 4; k++) load_word(11'h020 + 11'(k), ea[k]);
        for (int k = 0; k < 4; k++) load_word(11'h120 + 11'(k), eb[k]);
        load_end();
        // start held high from cycle 2 through the DONE cycle, with other inputs changed
        run_job(1'b0, 11'h020, 11'h120, 11'h220, 12'd4, 1'b1, d, w, b);
        vec++; if (d !== 8 || w !== 4) begin errs++; $display("FAIL busy_ignore_timing: got done %0d writes %0d, expected 8 4", d, w); end
        vec++; if (b !== 0) begin errs++; $display("FAIL busy_ignore_timeline: got %0d bad cycles, expected 0", b); end
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (mem[11'h220 + 11'(k)] !== 6) begin
                errs++; $display("FAIL busy_ignore_result[%0d]: got %0d, expected 6", k, mem[11'h220 + 11'(k)]);
            end
        end
    endtask

    task automatic test_in_place();
        int d, w, b;
        int ea [4] = '{1000, -5, 32'h7FFFFFFF, 3};
        int eb [4] = '{24, 5, 1, -3};
        int ec [4] = '{1024, 0, 32'h80000000, 0};
        for (int k = 0; k < 4; k++) load_word(11'h040 + 11'(k), ea[k]);
        for (int k = 0; k < 4; k++) load_word(11'h140 + 11'(k), eb[k]);
        load_end();
        run_job(1'b0, 11'h040, 11'h140, 11'h040, 12'd4, 1'b0, d, w, b);
        vec++; if (d !== 8 || w !== 4 || b !== 0) begin errs++; $display("FAIL inplace_timing: got done %0d writes %0d bad %0d, expected 8 4 0", d, w, b); end
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (mem[11'h040 + 11'(k)] !== ec[k]) begin
                errs++; $display("FAIL inplace_result[%0d]: got %0d, expected %0d", k, mem[11'h040 + 11'(k)], ec[k]);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int d, w, b;
        start  = 1'b1;
        op     = 1'b0;
        base_a = 11'h050;
        base_b = 11'h150;
        base_c = 11'h350;
        len    = 12'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // cycle 3: element 2 read is being driven and element 0 is being written
        vec++; if (sram_write !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL midjob_pre: got write %0b busy %0b, expected 1 1", sram_write, busy); end
        #1 rst_n = 1'b0;
        #1;
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL midjob_busy: got %0b, expected 0", busy); end
        vec++; if (sram_write !== 1'b0) begin errs++; $display("FAIL midjob_write: got %0b, expected 0", sram_write); end
        vec++; if (sram_raddr_a !== 11'h000) begin errs++; $display("FAIL midjob_raddr: got %h, expected 000", sram_raddr_a); end
        load_word(11'h060, 2);
        load_word(11'h061, 4);
        load_word(11'h160, 3);
        load_word(11'h161, 5);
        load_end();
        rst_n = 1'b1;
        // start presented immediately so it is sampled on the first edge after release
        run_job(1'b1, 11'h060, 11'h160, 11'h260, 12'd2, 1'b0, d, w, b);
        vec++; if (d !== 6 || w !== 2 || b !== 0) begin errs++; $display("FAIL post_reset_timing: got done %0d writes %0d bad %0d, expected 6 2 0", d, w, b); end
        vec++; if (mem[11'h260] !== -1 || mem[11'h261] !== -1) begin errs++; $display("FAIL post_reset_result: got %0d %0d, expected -1 -1", mem[11'h260], mem[11'h261]); end
    endtask

    task automatic test_full_len();
        int d, w, b, miss;
        for (int k = 0; k < DEPTH; k++) load_word(11'(k), 3 * k + 1);
        load_end();
        run_job(1'b0, 11'h000, 11'h000, 11'h000, 12'd2048, 1'b0, d, w, b);
        vec++; if (d !== 2052) begin errs++; $display("FAIL full_done_cycle: got %0d, expected 2052", d); end
        vec++; if (w !== 2048) begin errs++; $display("FAIL full_write_count: got %0d, expected 2048", w); end
        vec++; if (b !== 0) begin errs++; $display("FAIL full_timeline: got %0d bad cycles, expected 0", b); end
        miss = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (mem[k] !== 2 * (3 * k + 1)) begin
                if (miss == 0) $display("FAIL full_result[%0d]: got %0d, expected %0d", k, mem[k], 2 * (3 * k + 1));
                miss++;
            end
        end
        vec++; if (miss != 0) errs++;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        base_a  = 11'h000;
        base_b  = 11'h000;
        base_c  = 11'h000;
        len     = 12'd0;
        ld_en   = 1'b0;
        ld_addr = 11'h000;
        ld_data = 32'sd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_add_basic();
        test_sub_wrap();
        test_addr_wrap();
        test_len_zero();
        test_busy_ignore();
        test_in_place();
        test_reset_mid_job();
        test_full_len();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
